// File: rtl/alu_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_issue_queue                                                 |
// | Purpose  : command FIFO + issue register + result register around a       |
// |            combinational 8-bit ALU. Option macro: ALU_ISSUE_STATS_EN.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+

package ALU_pkg;
  typedef enum logic [3:0] {
    Add   = 4'd0,
    Sub   = 4'd1,
    And   = 4'd2,
    Or    = 4'd3,
    Xor   = 4'd4,
    Shl   = 4'd5,
    Shr   = 4'd6,
    Equal = 4'd7
  } OpCode;
endpackage

module alu_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  ALU_pkg::OpCode           cmd_op,
  input  logic [7:0]               cmd_a,
  input  logic [7:0]               cmd_b,
  output ALU_pkg::OpCode           alu_op,
  output logic [7:0]               alu_a,
  output logic [7:0]               alu_b,
  input  logic [7:0]               alu_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [7:0]               res_data,
  output ALU_pkg::OpCode           res_op,
  output logic                     res_zero,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]              res_count,
  output logic                     ovf_flag
`endif
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;

  typedef struct packed {
    ALU_pkg::OpCode op;
    logic [7:0]     a;
    logic [7:0]     b;
  } cmd_t;

  cmd_t              r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_CW-1:0]   r_count;
  logic              r_iss_valid;
  cmd_t              r_iss;
  logic              r_res_valid;
  logic [7:0]        r_res_data;
  ALU_pkg::OpCode    r_res_op;

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_iss_adv;
  logic w_res_hs;

  assign w_full    = (r_count == c_CW'(DEPTH));
  assign cmd_ready = rst_n && !w_full;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_res_hs  = r_res_valid && res_ready;
  assign w_iss_adv = r_iss_valid && (!r_res_valid || res_ready);
  // Only stored entries can pop, so a push into an empty FIFO issues a cycle later.
  assign w_pop     = (r_count != '0) && (!r_iss_valid || w_iss_adv);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_iss_valid <= 1'b0;
      r_iss       <= '{op: ALU_pkg::Add, a: 8'h00, b: 8'h00};
    end else if (w_pop) begin
      r_iss_valid <= 1'b1;
      r_iss       <= r_mem[r_rd_ptr];
    end else if (w_iss_adv) begin
      r_iss_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_data  <= 8'h00;
      r_res_op    <= ALU_pkg::Add;
    end else if (w_iss_adv) begin
      r_res_valid <= 1'b1;
      r_res_data  <= alu_out;
      r_res_op    <= r_iss.op;
    end else if (w_res_hs) begin
      r_res_valid <= 1'b0;
    end
  end

  assign alu_op     = r_iss.op;
  assign alu_a      = r_iss.a;
  assign alu_b      = r_iss.b;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_op     = r_res_op;
  assign res_zero   = (r_res_data == 8'h00);
  assign fifo_count = r_count;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] r_res_count;
  logic        r_ovf_flag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res_count <= 16'h0000;
      r_ovf_flag  <= 1'b0;
    end else if (w_res_hs && (r_res_count != 16'hFFFF)) begin
      r_res_count <= r_res_count + 16'd1;
      if (r_res_count == 16'hFFFE) r_ovf_flag <= 1'b1;
    end
  end

  assign res_count = r_res_count;
  assign ovf_flag  = r_ovf_flag;
`endif

endmodule
`default_nettype wire

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Upstream feeder stage for the 8-bit combinational ALU (ALU_pkg::OpCode operations).
- Buffers incoming commands {op, A, B} in a small FIFO and holds the head command in an issue register that drives the ALU inputs.
- Captures the ALU output in a result register and presents it downstream with a valid/ready handshake.
- Gives the purely combinational ALU a registered, back-pressurable pipeline interface.

Parameters:
DEPTH, 4, command FIFO entries; power of two, >= 2.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst_n  input  1  synchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  queue can accept a command.
cmd_op  input  ALU_pkg::OpCode  operation.
cmd_a  input  8  operand A.
cmd_b  input  8  operand B.
alu_op  output  ALU_pkg::OpCode  to ALU op.
alu_a  output  8  to ALU A.
alu_b  output  8  to ALU B.
alu_out  input  8  from ALU out.
res_valid  output  1  result present.
res_ready  input  1  downstream accepts result.
res_data  output  8  registered ALU result.
res_op  output  ALU_pkg::OpCode  op that produced res_data.
res_zero  output  1  res_data == 8'h00.
fifo_count  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst_n low at a clock edge): FIFO emptied, fifo_count 0, issue register invalid, alu_op = ALU_pkg::Add, alu_a = alu_b = 0, res_valid 0, res_data 0, res_op = ALU_pkg::Add, res_zero 1.
- cmd_ready is forced 0 while rst_n is low.
- Reset mid-operation discards all queued, issued and unaccepted results; nothing is replayed.
- Push: when cmd_valid && cmd_ready. cmd_ready = !full (combinational from the count; no same-cycle pass-through when full).
- Pop into issue register when FIFO not empty && (!iss_valid || iss_adv).
- Simultaneous push and pop leave fifo_count unchanged.
- An empty FIFO cannot pop the same-cycle push; the entry is visible the next cycle.
- Pointers wrap modulo DEPTH.
- iss_adv = iss_valid && (!res_valid || res_ready).
- alu_op/alu_a/alu_b are driven directly from the issue register. They are stable while the issue register holds and keep their last values when invalid.
- On iss_adv: res_data <= alu_out, res_op <= iss_op, res_valid <= 1.
- Else if res_valid && res_ready: res_valid <= 0, with res_data/res_op held.
- res_data/res_op are stable while res_valid && !res_ready.
- No arithmetic inside the block. Results are whatever the ALU returns, including wrap (8'h00 - 8'h01 = 8'hFF) and 8'h00 for unlisted opcodes.
- Latency: command accepted at edge T, issued at T+1, res_valid at T+2.
- Throughput: one result per cycle when res_ready is held high.
- Total capacity under back-pressure is DEPTH + 2 (FIFO + issue + result).

Optional Feature:
- Macro: ALU_ISSUE_STATS_EN.
- Defined: adds output res_count (16 bits), the number of completed result handshakes (res_valid && res_ready).
  - Saturates at 16'hFFFF.
  - Cleared by reset.
  - Adds output ovf_flag: sticky 1 once res_count saturates, cleared only by reset.
- Undefined: neither port exists and there is no counter logic. All other behaviour is identical.

Test Plan:
- Add, res_ready=1: push {Add, 8'h12, 8'h34} at edge T -> res_valid=1 at T+2, res_data=8'h46, res_op=Add, res_zero=0; res_valid=0 at T+3.
- Sub wrap, plus Equal: push {Sub, 8'h00, 8'h01} then {Equal, 8'h5A, 8'h5A} back-to-back -> results 8'hFF then 8'h01 on consecutive cycles, in order.
- Back-pressure, DEPTH=4, res_ready=0: push 8 commands with cmd_valid held -> exactly 6 accepted, cmd_ready=0 with fifo_count=4. First result is held stable. Raising res_ready drains all 6 results in order, one per cycle.
- Zero flag, plus simultaneous push/pop: {Xor, 8'hA5, 8'hA5} -> res_data=8'h00, res_zero=1. A push during a pop at fifo_count=2 keeps fifo_count at 2.
- Reset mid-operation: 3 commands queued, one result pending; assert rst_n=0 for one edge -> res_valid=0, fifo_count=0, alu_a=alu_b=0. No stale result appears after rst_n returns to 1; cmd_ready=1 the cycle after release.
- ALU_ISSUE_STATS_EN defined: complete 5 handshakes -> res_count=5. Force the counter to 16'hFFFE and complete 3 more -> res_count=16'hFFFF, ovf_flag=1.
